// File: rtl/simple_risc_pkg.sv
// Shared widths, fetch FSM encoding and reset defaults for the Simple RISC front end.
package simple_risc_pkg;

    localparam int          INST_W           = 32;
    localparam int          BYTES_PER_INST   = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_assembler.sv
// Four byte lanes assembled little-endian into one instruction word; clear wins over write.
module inst_assembler
    import simple_risc_pkg::*;
(
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              we,
    input  logic [1:0]        lane,
    input  logic [7:0]        din,
    output logic [INST_W-1:0] word
);

    logic [BYTES_PER_INST-1:0][7:0] lanes_q;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            lanes_q <= '0;
        end else if (clr) begin
            lanes_q <= '0;
        end else if (we) begin
            lanes_q[lane] <= din;
        end
    end

    assign word = lanes_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: issues four byte reads, assembles the word and hands it
// to decode with valid/ready; owns the fetch PC and takes branch redirects at top priority.
module fetch_sequencer
    import simple_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MEM_BYTES = 1024
) (
    input  logic              Clk,
    input  logic              reset_n,
    output logic              mem_rd,
    output logic [31:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    input  logic              isBranchTaken,
    input  logic [31:0]       branchPC,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       pc_current,
    output logic [INST_W-1:0] Instruction,
    output fetch_state_e      state_dbg
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

    // Handshake: a byte read issues on mem_rd & mem_gnt and its data is on mem_rdata
    // the next cycle; an instruction transfers on inst_valid & inst_ready unless a
    // branch is taken in that same cycle, in which case decode discards it.

    fetch_state_e state, state_nxt;
    logic [31:0]  pc;
    logic [2:0]   issue_cnt;
    logic [2:0]   rcv_cnt;
    logic         rsp_pend;
    logic         issue;
    logic         capture;
    logic         transfer;

    assign issue    = mem_rd & mem_gnt;
    assign capture  = rsp_pend & ~isBranchTaken;
    assign transfer = (state == HOLD) & inst_ready & ~isBranchTaken;
    assign mem_addr = (pc + 32'(issue_cnt)) & ADDR_MASK;
    assign state_dbg = state;

    always_comb begin
        state_nxt  = state;
        mem_rd     = 1'b0;
        inst_valid = 1'b0;
        pc_current = '0;
        case (state)
            FETCH: begin
                // Held off while reset is asserted so no request leaks out of reset.
                mem_rd = reset_n & (issue_cnt < 3'd4) & ~isBranchTaken;
                if (capture && rcv_cnt == 3'd3) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                pc_current = pc;
                if (transfer) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (isBranchTaken) begin
            state_nxt = FETCH;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FETCH;
            pc        <= RESET_PC & ADDR_MASK;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            rsp_pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (isBranchTaken) begin
                pc        <= branchPC & ~32'h3 & ADDR_MASK;
                issue_cnt <= '0;
                rcv_cnt   <= '0;
                rsp_pend  <= 1'b0;
            end else if (transfer) begin
                pc        <= (pc + 32'd4) & ADDR_MASK;
                issue_cnt <= '0;
                rcv_cnt   <= '0;
                rsp_pend  <= 1'b0;
            end else begin
                rsp_pend <= issue;
                if (issue) begin
                    issue_cnt <= issue_cnt + 3'd1;
                end
                if (capture) begin
                    rcv_cnt <= rcv_cnt + 3'd1;
                end
            end
        end
    end

    inst_assembler u_asm (
        .Clk     (Clk),
        .reset_n (reset_n),
        .clr     (isBranchTaken | transfer),
        .we      (capture),
        .lane    (rcv_cnt[1:0]),
        .din     (mem_rdata),
        .word    (Instruction)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory model plus a PC/instruction reference model.
module tb_fetch_sequencer;
    import simple_risc_pkg::*;

    localparam int          MEM_BYTES = 1024;
    localparam logic [31:0] MASK      = 32'(MEM_BYTES - 1);

    logic         Clk;
    logic         reset_n;
    logic         mem_rd;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic [7:0]   mem_rdata;
    logic         isBranchTaken;
    logic [31:0]  branchPC;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  pc_current;
    logic [31:0]  Instruction;
    fetch_state_e dbg_state;

    int tests_run;
    int tests_failed;
    int oob_cnt;

    logic [7:0]  mem [MEM_BYTES];
    logic [31:0] model_pc;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] obs_pc_q[$];
    logic [31:0] obs_inst_q[$];
    logic [31:0] iss_q[$];

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .Clk           (Clk),
        .reset_n       (reset_n),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rdata     (mem_rdata),
        .isBranchTaken (isBranchTaken),
        .branchPC      (branchPC),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .pc_current    (pc_current),
        .Instruction   (Instruction),
        .state_dbg     (dbg_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    // memory model, issue log and instruction-level reference model
    always @(posedge Clk) begin
        mem_rdata <= 8'($urandom);
        if (reset_n) begin
            if (mem_rd && mem_gnt) begin
                iss_q.push_back(mem_addr);
                if (mem_addr >= 32'(MEM_BYTES)) oob_cnt++;
                mem_rdata <= mem[mem_addr[9:0]];
            end
            if (isBranchTaken) begin
                model_pc = (branchPC & ~32'h3) & MASK;
            end else if (inst_valid && inst_ready) begin
                exp_pc_q.push_back(model_pc);
                exp_inst_q.push_back(ref_word(model_pc));
                obs_pc_q.push_back(pc_current);
                obs_inst_q.push_back(Instruction);
                model_pc = (model_pc + 32'd4) & MASK;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_model();
        exp_pc_q.delete();
        exp_inst_q.delete();
        obs_pc_q.delete();
        obs_inst_q.delete();
        iss_q.delete();
        model_pc = 32'h0;
    endtask

    task automatic apply_reset();
        @(posedge Clk);
        #1;
        reset_n       = 1'b0;
        isBranchTaken = 1'b0;
        branchPC      = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        clear_model();
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!inst_valid && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic fill_random_mem();
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
        isBranchTaken = 1'b0; branchPC = 32'h0;
        #1;
        reset_n = 1'b0;
        #2;
        tests_run++;
        if (mem_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
        tests_run++;
        if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        tests_run++;
        if (pc_current !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected 0", pc_current); end
        tests_run++;
        if (Instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h expected 0", Instruction); end
    endtask

    task automatic test_basic();
        int n;
        mem_gnt = 1'b1; inst_ready = 1'b1;
        apply_reset();
        wait_valid(20, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL basic_first_latency: got %0d expected 5", n); end
        tests_run++;
        if (Instruction !== 32'h44332211 || pc_current !== 32'h0) begin
            tests_failed++;
            $display("FAIL basic_inst0: got %h@%h expected 44332211@00000000", Instruction, pc_current);
        end
        tick();
        wait_valid(20, n);
        tests_run++;
        if (n !== 5) begin tests_failed++; $display("FAIL basic_steady_latency: got %0d expected 5 after transfer", n); end
        tests_run++;
        if (Instruction !== 32'h88776655 || pc_current !== 32'h4) begin
            tests_failed++;
            $display("FAIL basic_inst1: got %h@%h expected 88776655@00000004", Instruction, pc_current);
        end
    endtask

    task automatic test_gnt_toggle();
        int hold_bad;
        int seq_bad;
        int cycles;
        logic        prev_rd, prev_gnt;
        logic [31:0] prev_addr;
        hold_bad = 0; seq_bad = 0; cycles = 0;
        inst_ready = 1'b1; mem_gnt = 1'b1;
        apply_reset();
        while (obs_pc_q.size() < 2 && cycles < 100) begin
            mem_gnt   = cycles[0] ? 1'b0 : 1'b1;
            #1;
            prev_rd   = mem_rd;
            prev_gnt  = mem_gnt;
            prev_addr = mem_addr;
            tick();
            if (prev_rd && !prev_gnt && mem_rd && mem_addr !== prev_addr) hold_bad++;
            cycles++;
        end
        mem_gnt = 1'b1;
        tests_run++;
        if (hold_bad !== 0) begin tests_failed++; $display("FAIL gnt_addr_hold: got %0d changes expected 0", hold_bad); end
        if (iss_q.size() < 8) seq_bad = 8;
        else for (int i = 0; i < 8; i++) if (iss_q[i] !== 32'(i)) seq_bad++;
        tests_run++;
        if (seq_bad !== 0) begin tests_failed++; $display("FAIL gnt_issue_seq: got %0d bad addresses expected 0", seq_bad); end
        tests_run++;
        if (obs_pc_q.size() < 2) begin
            tests_failed++;
            $display("FAIL gnt_transfers: got %0d expected 2", obs_pc_q.size());
        end else if (obs_inst_q[0] !== 32'h44332211 || obs_inst_q[1] !== 32'h88776655 ||
                     obs_pc_q[0] !== 32'h0 || obs_pc_q[1] !== 32'h4) begin
            tests_failed++;
            $display("FAIL gnt_insts: got %h@%h %h@%h expected 44332211@0 88776655@4",
                     obs_inst_q[0], obs_pc_q[0], obs_inst_q[1], obs_pc_q[1]);
        end
    endtask

    task automatic test_ready_stall();
        int n;
        int bad;
        bad = 0;
        fill_random_mem();
        mem_gnt = 1'b1; inst_ready = 1'b0;
        apply_reset();
        wait_valid(20, n);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!inst_valid || mem_rd || pc_current !== 32'h0 || Instruction !== ref_word(32'h0)) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        tests_run++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL stall_next_fetch: got rd=%b addr=%h expected rd=1 addr=00000004", mem_rd, mem_addr);
        end
        wait_valid(20, n);
        tests_run++;
        if (obs_pc_q.size() !== 1 || pc_current !== 32'h4 || Instruction !== ref_word(32'h4)) begin
            tests_failed++;
            $display("FAIL stall_one_transfer: got %0d transfers, %h@%h expected 1, %h@00000004",
                     obs_pc_q.size(), Instruction, pc_current, ref_word(32'h4));
        end
    endtask

    task automatic test_branch_partial();
        int n;
        mem_gnt = 1'b1; inst_ready = 1'b1;
        apply_reset();
        repeat (3) tick();
        isBranchTaken = 1'b1; branchPC = 32'h103;
        #1;
        tests_run++;
        if (mem_rd !== 1'b0) begin tests_failed++; $display("FAIL branch_cycle_rd: got %b expected 0", mem_rd); end
        tick();
        isBranchTaken = 1'b0;
        #1;
        tests_run++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL branch_restart_addr: got rd=%b addr=%h expected rd=1 addr=00000100", mem_rd, mem_addr);
        end
        wait_valid(20, n);
        tests_run++;
        if (n !== 5 || pc_current !== 32'h100 || Instruction !== ref_word(32'h100)) begin
            tests_failed++;
            $display("FAIL branch_partial_inst: got %h@%h after %0d expected %h@00000100 after 5",
                     Instruction, pc_current, n, ref_word(32'h100));
        end
    endtask

    task automatic test_branch_on_transfer();
        int n;
        logic [31:0] t0, t1, t2;
        t0 = $urandom; t1 = $urandom; t2 = $urandom;
        mem_gnt = 1'b1; inst_ready = 1'b1;
        apply_reset();
        wait_valid(20, n);
        isBranchTaken = 1'b1; branchPC = t0;
        tick();
        isBranchTaken = 1'b0;
        wait_valid(20, n);
        tests_run++;
        if (pc_current !== (t0 & ~32'h3 & MASK) || Instruction !== ref_word(t0 & ~32'h3 & MASK)) begin
            tests_failed++;
            $display("FAIL branch_xfer_target: got %h@%h expected %h@%h", Instruction, pc_current,
                     ref_word(t0 & ~32'h3 & MASK), t0 & ~32'h3 & MASK);
        end
        isBranchTaken = 1'b1; branchPC = t1;
        tick();
        branchPC = t2;
        tick();
        isBranchTaken = 1'b0;
        wait_valid(20, n);
        tests_run++;
        if (pc_current !== (t2 & ~32'h3 & MASK)) begin
            tests_failed++;
            $display("FAIL branch_last_wins: got %h expected %h", pc_current, t2 & ~32'h3 & MASK);
        end
        tests_run++;
        if (obs_pc_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL branch_no_transfer: got %0d transfers expected 0", obs_pc_q.size());
        end
    endtask

    task automatic test_wrap_and_reset();
        int n;
        int seq_bad;
        seq_bad = 0;
        mem_gnt = 1'b1; inst_ready = 1'b1;
        apply_reset();
        isBranchTaken = 1'b1; branchPC = 32'h3FE;
        tick();
        isBranchTaken = 1'b0;
        wait_valid(20, n);
        tests_run++;
        if (pc_current !== 32'h3FC || Instruction !== ref_word(32'h3FC)) begin
            tests_failed++;
            $display("FAIL wrap_inst: got %h@%h expected %h@000003fc", Instruction, pc_current, ref_word(32'h3FC));
        end
        if (iss_q.size() < 4) seq_bad = 4;
        else for (int i = 0; i < 4; i++) if (iss_q[i] !== 32'h3FC + 32'(i)) seq_bad++;
        tests_run++;
        if (seq_bad !== 0) begin tests_failed++; $display("FAIL wrap_issue_seq: got %0d bad addresses expected 0", seq_bad); end
        tick();
        tests_run++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next_addr: got rd=%b addr=%h expected rd=1 addr=00000000", mem_rd, mem_addr);
        end
        repeat (2) tick();
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (mem_rd !== 1'b0 || inst_valid !== 1'b0 || pc_current !== 32'h0 || Instruction !== 32'h0) begin
            tests_failed++;
            $display("FAIL midfetch_reset: got rd=%b v=%b pc=%h inst=%h expected all 0",
                     mem_rd, inst_valid, pc_current, Instruction);
        end
        @(posedge Clk);
        #1;
        clear_model();
        reset_n = 1'b1;
        wait_valid(20, n);
        tests_run++;
        if (n !== 5 || pc_current !== 32'h0 || Instruction !== ref_word(32'h0)) begin
            tests_failed++;
            $display("FAIL post_reset_inst: got %h@%h after %0d expected %h@00000000 after 5",
                     Instruction, pc_current, n, ref_word(32'h0));
        end
    endtask

    task automatic test_random();
        fill_random_mem();
        mem_gnt = 1'b1; inst_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            mem_gnt       = ($urandom_range(0, 3) != 0);
            inst_ready    = ($urandom_range(0, 2) != 0);
            isBranchTaken = ($urandom_range(0, 19) == 0);
            branchPC      = $urandom;
            tick();
        end
        isBranchTaken = 1'b0;
        tests_run++;
        if (obs_pc_q.size() < 20) begin
            tests_failed++;
            $display("FAIL random_progress: got %0d transfers expected at least 20", obs_pc_q.size());
        end
        while (obs_pc_q.size() > 0 && exp_pc_q.size() > 0) begin
            logic [31:0] op, oi, ep, ei;
            op = obs_pc_q.pop_front(); oi = obs_inst_q.pop_front();
            ep = exp_pc_q.pop_front(); ei = exp_inst_q.pop_front();
            tests_run++;
            if (op !== ep || oi !== ei) begin
                tests_failed++;
                $display("FAIL random_xfer: got %h@%h expected %h@%h", oi, op, ei, ep);
            end
        end
        tests_run++;
        if (oob_cnt !== 0) begin tests_failed++; $display("FAIL addr_range: got %0d out-of-range issues expected 0", oob_cnt); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; oob_cnt = 0;
        model_pc = 32'h0;
        mem_rdata = 8'h0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h0;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
        test_reset();
        test_basic();
        test_gnt_toggle();
        test_ready_stall();
        test_branch_partial();
        test_branch_on_transfer();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
